obj_line_pingpong: RTL and testbench
====================================

# obj_line_pingpong

Parametrised ping-pong line buffer for the OBJ (sprite) pipeline. The OBJ renderer composites one scanline into the back bank while the compositor reads the previous line from the front bank. Each pixel is resolved per column by OBJ priority and by transparency, and an OBJ-window mask is kept separately. On a `swap` pulse at the line boundary, the banks exchange roles and the new back bank is emptied by an internal clear sweep. While the sweep runs, writes are back-pressured through a valid/ready handshake.

## Interface
- `COLS`, 240: visible columns per line.
- `COL_W`, 8: column index width; must satisfy `COLS <= 2**COL_W`.
- `COLOR_W`, 16: colour/palette payload width.
- `PRIO_W`, 2: OBJ priority width; a lower value wins.

- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `wvalid` in 1: write request from the renderer.
- `wready` out 1: the back bank accepts a write this cycle.
- `wcol` in COL_W: write column.
- `wcolor` in COLOR_W: pixel colour.
- `wprio` in PRIO_W: pixel priority.
- `wsemi` in 1: semi-transparent OBJ.
- `wtransparent` in 1: pixel is transparent. It is accepted but has no effect.
- `wobjwin` in 1: pixel belongs to an OBJ-window sprite; it sets the mask only.
- `swap` in 1: single-cycle pulse at the line boundary.
- `rcol` in COL_W: read column of the front bank.
- `rcolor` out COLOR_W, `rprio` out PRIO_W, `rsemi` out 1, `ropaque` out 1, `rwin` out 1: registered read of the front-bank entry.
- `busy` out 1: a clear sweep is in progress or a swap is pending.

## Operation
- Each bank holds COLS entries of {opaque, prio, semi, color, win}. The empty entry is all zeros.
- `front` is a one-bit bank select; the back bank is `~front`.
- FSM states:
  - RESET_CLR: entered on reset. It sweeps both banks in parallel.
  - IDLE: writes are accepted.
  - CLEAR: sweeps the back bank.
- FSM transitions:
  - RESET_CLR → IDLE after the last column.
  - IDLE + `swap` → CLEAR, with `front` toggled on the same edge.
  - CLEAR → IDLE after column COLS-1. If a swap is pending, CLEAR instead goes directly to CLEAR again, with `front` toggled and the pending flag cleared.
- Clear sweep:
  - A `clr_col` counter runs 0..COLS-1 and writes the empty entry to one column per cycle.
  - The counter resets to 0 when entering either sweep state.
- `wready` = 1 only in IDLE.
- A write is accepted on `wvalid & wready` only; `wvalid` without `wready` has no effect.
- Write resolution at the back-bank column `wcol`:
  - `wcol >= COLS`: the write is ignored.
  - `wtransparent = 1`: no change.
  - `wobjwin = 1`: set `win` only; the colour, priority and opaque fields are untouched.
  - Otherwise, replace the colour fields when the entry is not opaque, or when `wprio < stored prio` (strictly less).
  - On an equal-priority tie, the earlier-written (lower OAM index) pixel is kept.
  - A replacing write sets opaque = 1.
- Read:
  - On each edge, the outputs register the front-bank entry at `rcol`.
  - `rcol >= COLS` registers the empty entry.
  - Reads are never stalled; the sweep only touches the back bank.
- Reset mid-operation:
  - Any in-flight sweep is abandoned.
  - `front` = 0 and the pending flag = 0.
  - The FSM enters RESET_CLR.

## Timing
- Reset values: `wready` 0, `busy` 1, all read outputs 0, `front` 0. `busy` stays 1 until RESET_CLR completes.
- Reset sweep: with `reset` high at edge R and low afterwards, `wready` rises in the cycle after edge R+COLS.
- Swap sampled at edge S:
  - The read outputs reflect the new front bank from edge S+1.
  - `wready` = 0 for cycles S+1..S+COLS and returns to 1 at S+COLS+1.
- Swap during CLEAR: the swap is latched (only one can be pending). Further swaps while one is pending are dropped.
- Swap and an accepted write on the same edge: the write lands in the old back bank, which becomes the new front, so it is visible to reads.
- Write latency: an accepted write at edge N is visible to a read of the same bank issued at edge N+1.
- Read latency: 1 cycle from `rcol`.

## Structure
- Package `obj_pkg`:
  - `obj_pixel_t` packed struct (opaque, prio, semi, color, win), parametrised through package constants COLOR_W and PRIO_W.
  - `OBJ_PIXEL_EMPTY` constant.
  - FSM enum `obj_lb_state_e`.
- Sub-module `obj_line_bank`: one bank of COLS `obj_pixel_t` registers. It has one write port with a priority-compare enable, a clear port addressed by `clr_col`, and one combinational read port. The top instantiates two banks and holds the FSM, `front`, `clr_col` and the pending-swap flag.

## Test plan
- Reset, then hold `wvalid` = 1: `wready` = 0 for COLS = 240 cycles, then 1. All reads return 0 after the first swap.
- Back-bank writes to col 10: (prio 2, color 0x1234), then (prio 1, 0x5678), then (prio 1, 0x9ABC). After a swap, reading col 10 → `rcolor` 0x5678, `rprio` 1, `ropaque` 1.
- Writes with `wtransparent` to col 5 and with `wobjwin` to col 6, then a swap: col 5 reads empty; col 6 reads `rwin` 1, `ropaque` 0.
- Swap, then hold `wvalid` to col 3 for the whole sweep: no write lands until cycle S+241. The first accepted write is then readable after the next swap.
- Second swap issued at sweep cycle 100: `busy` stays 1 and `front` toggles at the end of the sweep. A second full 240-cycle sweep follows, and the old back data is lost.
- `rcol` = 240 and 255 → all read outputs 0. `wcol` = 250 → no bank changes.

Source files
------------

// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - OBJ line-buffer pixel type, empty constant and FSM states.
package obj_pkg;

  localparam int COLOR_W = 16;
  localparam int PRIO_W  = 2;

  typedef struct packed {
    logic              opaque;
    logic [PRIO_W-1:0] prio;
    logic              semi;
    logic [COLOR_W-1:0] color;
    logic              win;
  } obj_pixel_t;

  localparam obj_pixel_t OBJ_PIXEL_EMPTY = '0;

  typedef enum logic [1:0] {
    RESET_CLR = 2'd0,
    IDLE      = 2'd1,
    CLEAR     = 2'd2
  } obj_lb_state_e;

endpackage

// File: rtl/obj_line_bank.sv
// rtl/obj_line_bank.sv - One OBJ scanline bank: priority-resolved write, clear port,
// combinational read.
module obj_line_bank
  import obj_pkg::*;
#(
  parameter int COLS  = 240,
  parameter int COL_W = 8
) (
  input  logic               clock,
  input  logic               wen,
  input  logic [COL_W-1:0]   wcol,
  input  logic [PRIO_W-1:0]  wprio,
  input  logic [COLOR_W-1:0] wcolor,
  input  logic               wsemi,
  input  logic               wobjwin,
  input  logic               clr_en,
  input  logic [COL_W-1:0]   clr_col,
  input  logic [COL_W-1:0]   rcol,
  output obj_pixel_t         rdata
);

  localparam logic [COL_W:0] COLS_LIM = (COL_W+1)'(COLS);

  obj_pixel_t mem [COLS];
  obj_pixel_t cur;
  logic       take;

  assign cur = mem[wcol];
  // Strict compare keeps the earlier (lower OAM index) pixel on a priority tie.
  assign take = ~cur.opaque | (wprio < cur.prio);

  always_ff @(posedge clock) begin
    if (clr_en) begin
      mem[clr_col] <= OBJ_PIXEL_EMPTY;
    end else if (wen) begin
      if (wobjwin) begin
        mem[wcol].win <= 1'b1;
      end else if (take) begin
        mem[wcol] <= '{opaque: 1'b1, prio: wprio, semi: wsemi, color: wcolor, win: cur.win};
      end
    end
  end

  assign rdata = ({1'b0, rcol} < COLS_LIM) ? mem[rcol] : OBJ_PIXEL_EMPTY;

endmodule

// File: rtl/obj_line_pingpong.sv
// rtl/obj_line_pingpong.sv - Ping-pong OBJ line buffer: two banks, bank select,
// clear-sweep FSM and write back-pressure.
module obj_line_pingpong #(
  parameter int COLS    = 240,
  parameter int COL_W   = 8,
  parameter int COLOR_W = obj_pkg::COLOR_W,
  parameter int PRIO_W  = obj_pkg::PRIO_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wvalid,
  output logic               wready,
  input  logic [COL_W-1:0]   wcol,
  input  logic [COLOR_W-1:0] wcolor,
  input  logic [PRIO_W-1:0]  wprio,
  input  logic               wsemi,
  input  logic               wtransparent,
  input  logic               wobjwin,
  input  logic               swap,
  input  logic [COL_W-1:0]   rcol,
  output logic [COLOR_W-1:0] rcolor,
  output logic [PRIO_W-1:0]  rprio,
  output logic               rsemi,
  output logic               ropaque,
  output logic               rwin,
  output logic               busy
);

  localparam logic [COL_W:0]   COLS_LIM = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS-1);

  obj_pkg::obj_lb_state_e state_q, state_d;
  logic             front_q, front_d;
  logic             pend_q, pend_d;
  logic [COL_W-1:0] clr_col_q, clr_col_d;
  obj_pkg::obj_pixel_t rd0, rd1, rd_q;

  logic sweep_last, accept, wr_hit, clr_all, clr_back;
  logic wen0, wen1, clr0, clr1;

  assign sweep_last = (clr_col_q == LAST_COL);
  assign wready     = (state_q == obj_pkg::IDLE);
  assign busy       = (state_q != obj_pkg::IDLE) | pend_q;

  assign accept   = wvalid & wready & ~reset;
  assign wr_hit   = accept & ({1'b0, wcol} < COLS_LIM) & ~wtransparent;
  assign clr_all  = (state_q == obj_pkg::RESET_CLR) & ~reset;
  assign clr_back = (state_q == obj_pkg::CLEAR) & ~reset;

  // The back bank is ~front: bank 0 is back when front_q is 1.
  assign wen0 = wr_hit & front_q;
  assign wen1 = wr_hit & ~front_q;
  assign clr0 = clr_all | (clr_back & front_q);
  assign clr1 = clr_all | (clr_back & ~front_q);

  obj_line_bank #(.COLS(COLS), .COL_W(COL_W)) u_bank0 (
    .clock   (clock),
    .wen     (wen0),
    .wcol    (wcol),
    .wprio   (wprio),
    .wcolor  (wcolor),
    .wsemi   (wsemi),
    .wobjwin (wobjwin),
    .clr_en  (clr0),
    .clr_col (clr_col_q),
    .rcol    (rcol),
    .rdata   (rd0)
  );

  obj_line_bank #(.COLS(COLS), .COL_W(COL_W)) u_bank1 (
    .clock   (clock),
    .wen     (wen1),
    .wcol    (wcol),
    .wprio   (wprio),
    .wcolor  (wcolor),
    .wsemi   (wsemi),
    .wobjwin (wobjwin),
    .clr_en  (clr1),
    .clr_col (clr_col_q),
    .rcol    (rcol),
    .rdata   (rd1)
  );

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    pend_d    = pend_q;
    clr_col_d = clr_col_q;
    unique case (state_q)
      obj_pkg::RESET_CLR: begin
        clr_col_d = clr_col_q + 1'b1;
        if (sweep_last) begin
          state_d   = obj_pkg::IDLE;
          clr_col_d = '0;
        end
      end
      obj_pkg::IDLE: begin
        if (swap) begin
          state_d   = obj_pkg::CLEAR;
          front_d   = ~front_q;
          clr_col_d = '0;
        end
      end
      obj_pkg::CLEAR: begin
        clr_col_d = clr_col_q + 1'b1;
        if (swap) begin
          pend_d = 1'b1;
        end
        // A swap arriving on the final sweep column is honoured like a latched one.
        if (sweep_last) begin
          clr_col_d = '0;
          if (pend_q | swap) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
          end else begin
            state_d = obj_pkg::IDLE;
          end
        end
      end
      default: begin
        state_d   = obj_pkg::RESET_CLR;
        clr_col_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= obj_pkg::RESET_CLR;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      clr_col_q <= '0;
      rd_q      <= obj_pkg::OBJ_PIXEL_EMPTY;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      clr_col_q <= clr_col_d;
      rd_q      <= front_q ? rd1 : rd0;
    end
  end

  assign rcolor  = rd_q.color;
  assign rprio   = rd_q.prio;
  assign rsemi   = rd_q.semi;
  assign ropaque = rd_q.opaque;
  assign rwin    = rd_q.win;

endmodule

// File: tb/tb_obj_line_pingpong.sv
// tb/tb_obj_line_pingpong.sv - Self-checking bench for obj_line_pingpong against a
// behavioural line-buffer model.
module tb_obj_line_pingpong;

  localparam int COLS = 240;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  wcol = '0;
  logic [15:0] wcolor = '0;
  logic [1:0]  wprio = '0;
  logic        wsemi = 1'b0;
  logic        wtransparent = 1'b0;
  logic        wobjwin = 1'b0;
  logic        swap = 1'b0;
  logic [7:0]  rcol = '0;
  logic [15:0] rcolor;
  logic [1:0]  rprio;
  logic        rsemi, ropaque, rwin, busy;

  obj_line_pingpong #(.COLS(COLS), .COL_W(8), .COLOR_W(16), .PRIO_W(2)) dut (
    .clock(clock), .reset(reset), .wvalid(wvalid), .wready(wready), .wcol(wcol),
    .wcolor(wcolor), .wprio(wprio), .wsemi(wsemi), .wtransparent(wtransparent),
    .wobjwin(wobjwin), .swap(swap), .rcol(rcol), .rcolor(rcolor), .rprio(rprio),
    .rsemi(rsemi), .ropaque(ropaque), .rwin(rwin), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: two arrays of line pixels, a bank select, and "cycles of sweep left".
  bit        m_opq   [2][COLS];
  bit [1:0]  m_prio  [2][COLS];
  bit        m_semi  [2][COLS];
  bit [15:0] m_color [2][COLS];
  bit        m_win   [2][COLS];
  bit        m_known [2][COLS];
  int        m_front = 0;
  int        m_left  = 0;
  bit        m_rst   = 0;
  bit        m_pend  = 0;
  logic [20:0] exp_rd = '0;
  bit        exp_known = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_wipe(input int b, input int c);
    m_opq[b][c] = 0; m_prio[b][c] = 0; m_semi[b][c] = 0;
    m_color[b][c] = 0; m_win[b][c] = 0; m_known[b][c] = 1;
  endtask

  task automatic model_edge();
    int b;
    int c;
    logic [20:0] nrd;
    bit nknown;
    b = 1 - m_front;
    if (rcol >= COLS) begin
      nrd = '0; nknown = 1;
    end else begin
      nrd = {m_opq[m_front][rcol], m_prio[m_front][rcol], m_semi[m_front][rcol],
             m_color[m_front][rcol], m_win[m_front][rcol]};
      nknown = m_known[m_front][rcol];
    end
    if (reset) begin
      exp_rd = '0; exp_known = 1;
      m_front = 0; m_left = COLS; m_rst = 1; m_pend = 0;
      return;
    end
    exp_rd = nrd; exp_known = nknown;
    if (m_left == 0) begin
      if (wvalid && wcol < COLS && !wtransparent) begin
        if (wobjwin) m_win[b][wcol] = 1;
        else if (!m_opq[b][wcol] || wprio < m_prio[b][wcol]) begin
          m_opq[b][wcol] = 1; m_prio[b][wcol] = wprio;
          m_semi[b][wcol] = wsemi; m_color[b][wcol] = wcolor;
        end
      end
      if (swap) begin
        m_front = 1 - m_front; m_left = COLS;
      end
    end else begin
      c = COLS - m_left;
      model_wipe(b, c);
      if (m_rst) model_wipe(m_front, c);
      else if (swap) m_pend = 1;
      m_left--;
      if (m_left == 0) begin
        m_rst = 0;
        if (m_pend) begin
          m_front = 1 - m_front; m_left = COLS; m_pend = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_eq("wready", wready, (m_left == 0));
    check_eq("busy", busy, (m_left != 0) || m_pend);
    if (exp_known) check_eq("rd_entry", {ropaque, rprio, rsemi, rcolor, rwin}, exp_rd);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wready && n < 1000) begin
      tick();
      n++;
    end
    if (!wready) check_eq("wready_timeout", wready, 1);
  endtask

  task automatic put(input int col, input int color, input int prio,
                     input bit transp, input bit win);
    wvalid = 1; wcol = 8'(col); wcolor = 16'(color); wprio = 2'(prio);
    wtransparent = transp; wobjwin = win;
    tick();
    wvalid = 0; wtransparent = 0; wobjwin = 0;
  endtask

  task automatic swap_wait(output int n);
    swap = 1;
    tick();
    swap = 0;
    wait_ready(n);
  endtask

  task automatic read_col(input int col);
    rcol = 8'(col);
    tick();
  endtask

  initial begin
    int n;
    int k;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < COLS; c++) m_known[b][c] = 0;

    @(negedge clock);
    tick();
    check_eq("rst_rd", {ropaque, rprio, rsemi, rcolor, rwin}, 0);
    reset = 0;
    wvalid = 1; wcol = 8'd250;
    wait_ready(n);
    check_eq("reset_sweep_len", n, 240);
    wvalid = 0;

    swap_wait(n);
    check_eq("swap_sweep_len", n, 240);
    for (int c = 0; c < COLS; c += 7) read_col(c);

    put(10, 'h1234, 2, 0, 0);
    put(10, 'h5678, 1, 0, 0);
    put(10, 'h9ABC, 1, 0, 0);
    put(5, 'h1111, 0, 1, 0);
    put(6, 'h2222, 0, 0, 1);
    swap_wait(n);
    read_col(10);
    check_eq("col10_color", rcolor, 'h5678);
    check_eq("col10_prio", rprio, 1);
    check_eq("col10_opaque", ropaque, 1);
    read_col(5);
    check_eq("col5_empty", {ropaque, rprio, rsemi, rcolor, rwin}, 0);
    read_col(6);
    check_eq("col6_win", rwin, 1);
    check_eq("col6_opaque", ropaque, 0);

    swap = 1;
    tick();
    swap = 0;
    wvalid = 1; wcol = 8'd3; wprio = 2'd3; n = 0;
    while (!wready && n < 1000) begin
      wcolor = 16'h0100 + 16'(n);
      tick();
      n++;
    end
    check_eq("held_write_wait", n, 240);
    wcolor = 16'hBEEF;
    tick();
    wvalid = 0;
    swap_wait(n);
    read_col(3);
    check_eq("col3_first_write", rcolor, 'hBEEF);

    put(20, 'h4242, 0, 0, 0);
    swap = 1;
    tick();
    swap = 0;
    k = 1;
    while (!wready && k < 2000) begin
      swap = (k == 100);
      tick();
      check_eq("busy_pending", busy || wready, 1);
      k++;
    end
    swap = 0;
    check_eq("double_sweep_len", k, 481);
    swap_wait(n);
    read_col(20);
    check_eq("col20_lost", ropaque, 0);

    read_col(240);
    check_eq("rcol240", {ropaque, rprio, rsemi, rcolor, rwin}, 0);
    read_col(255);
    check_eq("rcol255", {ropaque, rprio, rsemi, rcolor, rwin}, 0);
    put(250, 'h7777, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 2999) == 0);
      wvalid       = $urandom_range(0, 1);
      wcol         = 8'($urandom_range(0, 255));
      wcolor       = 16'($urandom);
      wprio        = 2'($urandom_range(0, 3));
      wsemi        = $urandom_range(0, 1);
      wtransparent = ($urandom_range(0, 9) == 0);
      wobjwin      = ($urandom_range(0, 9) == 0);
      swap         = ($urandom_range(0, 199) == 0);
      rcol         = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) wcol = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rcol = 8'($urandom_range(0, 15));
      tick();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
